// File: rtl/uart_link_controller.sv
// uart_link_controller
// Shares one UART transmitter between two requesters (round-robin) and drains
// the UART receiver into a valid/ready stream. The UART has no TX-busy flag,
// so each frame is paced by an internal timer covering the frame plus a gap.

module uart_link_controller #(
    parameter int WORD_LENGTH  = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FRAME_BITS   = 11,
    parameter int GAP_CLKS     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic [WORD_LENGTH-1:0] data0,
    output logic                   ack0,
    input  logic                   req1,
    input  logic [WORD_LENGTH-1:0] data1,
    output logic                   ack1,
    output logic [WORD_LENGTH-1:0] DATATX,
    output logic                   Transmit,
    output logic                   tx_busy,
    input  logic                   RX_FLAG,
    input  logic [WORD_LENGTH-1:0] DATARX,
    input  logic                   ParityError,
    output logic                   Clear_RX_Flag,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_perr,
    output logic [7:0]             perr_count
);

    localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT + GAP_CLKS;
    localparam int TIMER_W    = $clog2(FRAME_CLKS);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(FRAME_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FIRE  = 2'd2,
        WAIT  = 2'd3
    } tx_state_e;

    tx_state_e              state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   last_grant_q, last_grant_d;
    logic [WORD_LENGTH-1:0] datatx_q, datatx_d;
    logic                   winner;

    logic [WORD_LENGTH-1:0] rx_data_q, rx_data_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   clr_pending_q, clr_pending_d;
    logic                   clear_q, clear_d;
    logic [7:0]             perr_count_q, perr_count_d;
    logic                   capture;

    // TX sequencing: arbitrate in IDLE, latch the winner's byte, fire, then wait out the frame
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        last_grant_d = last_grant_q;
        datatx_d     = datatx_q;
        winner       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winner       = (req0 && req1) ? ~last_grant_q : req1;
                    last_grant_d = winner;
                    datatx_d     = winner ? data1 : data0;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                state_d = FIRE;
            end
            FIRE: begin
                timer_d = TIMER_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RX drain: capture once per flag when the output slot is free or being consumed
    always_comb begin
        rx_data_d     = rx_data_q;
        rx_perr_d     = rx_perr_q;
        rx_valid_d    = rx_valid_q;
        clr_pending_d = clr_pending_q;
        clear_d       = 1'b0;
        perr_count_d  = perr_count_q;
        capture       = RX_FLAG && !clr_pending_q && (!rx_valid_q || rx_ready);
        if (capture) begin
            rx_data_d     = DATARX;
            rx_perr_d     = ParityError;
            rx_valid_d    = 1'b1;
            clr_pending_d = 1'b1;
            clear_d       = 1'b1;
            if (ParityError && (perr_count_q != 8'hFF)) begin
                perr_count_d = perr_count_q + 8'd1;
            end
        end else begin
            if (rx_valid_q && rx_ready) begin
                rx_valid_d = 1'b0;
            end
            if (!RX_FLAG) begin
                clr_pending_d = 1'b0;
            end
        end
    end

    // State registers for both paths, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            last_grant_q  <= 1'b1;
            datatx_q      <= '0;
            rx_data_q     <= '0;
            rx_perr_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            clr_pending_q <= 1'b0;
            clear_q       <= 1'b0;
            perr_count_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            last_grant_q  <= last_grant_d;
            datatx_q      <= datatx_d;
            rx_data_q     <= rx_data_d;
            rx_perr_q     <= rx_perr_d;
            rx_valid_q    <= rx_valid_d;
            clr_pending_q <= clr_pending_d;
            clear_q       <= clear_d;
            perr_count_q  <= perr_count_d;
        end
    end

    assign ack0          = (state_q == GRANT) && !last_grant_q;
    assign ack1          = (state_q == GRANT) && last_grant_q;
    assign Transmit      = (state_q == FIRE);
    assign tx_busy       = (state_q != IDLE);
    assign DATATX        = datatx_q;
    assign Clear_RX_Flag = clear_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_perr       = rx_perr_q;
    assign perr_count    = perr_count_q;

endmodule

// File: tb/tb_uart_link_controller.sv
// Testbench for uart_link_controller: directed steps with a scoreboard of
// expected grants and expected RX captures, checked as the DUT produces them.

module tb_uart_link_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       ack0;
    logic       req1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       ack1;
    logic [7:0] DATATX;
    logic       Transmit;
    logic       tx_busy;
    logic       RX_FLAG = 1'b0;
    logic [7:0] DATARX = 8'h00;
    logic       ParityError = 1'b0;
    logic       Clear_RX_Flag;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic [7:0] perr_count;

    typedef struct {
        logic       who;
        logic [7:0] data;
    } tx_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } rx_exp_t;

    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];
    int      ack_cycles[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int ack_count    = 0;
    int clr_count    = 0;
    int tx_pulses    = 0;
    int last_tx_cyc  = -1;
    int last_ack_cyc = -1;

    uart_link_controller dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .data0        (data0),
        .ack0         (ack0),
        .req1         (req1),
        .data1        (data1),
        .ack1         (ack1),
        .DATATX       (DATATX),
        .Transmit     (Transmit),
        .tx_busy      (tx_busy),
        .RX_FLAG      (RX_FLAG),
        .DATARX       (DATARX),
        .ParityError  (ParityError),
        .Clear_RX_Flag(Clear_RX_Flag),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_perr      (rx_perr),
        .perr_count   (perr_count)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1);
        req0  = r0;
        data0 = d0;
        req1  = r1;
        data1 = d1;
    endtask

    // Advance one clock, sample #1 after the edge, and score any grant or RX clear seen
    task automatic tickClock();
        tx_exp_t te;
        rx_exp_t re;
        @(posedge clk);
        #1;
        cyc++;
        if (Transmit) begin
            tx_pulses++;
            last_tx_cyc = cyc;
        end
        if (ack0 || ack1) begin
            ack_count++;
            last_ack_cyc = cyc;
            ack_cycles.push_back(cyc);
            if (tx_q.size() == 0) begin
                checkOutput("spurious_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                te = tx_q.pop_front();
                checkOutput("ack_who", {30'd0, ack1, ack0}, te.who ? 32'd2 : 32'd1);
                checkOutput("grant_datatx", {24'd0, DATATX}, {24'd0, te.data});
            end
        end
        if (Clear_RX_Flag) begin
            clr_count++;
            if (rx_q.size() == 0) begin
                checkOutput("spurious_clear", {31'd0, Clear_RX_Flag}, 32'd0);
            end else begin
                re = rx_q.pop_front();
                checkOutput("rx_data", {24'd0, rx_data}, {24'd0, re.data});
                checkOutput("rx_perr", {31'd0, rx_perr}, {31'd0, re.perr});
                checkOutput("rx_valid_on_capture", {31'd0, rx_valid}, 32'd1);
            end
        end
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tickClock();
        tickClock();
        reset = 1'b0;
        cyc = 0;
    endtask

    // Run until the transmitter goes idle, bounded; returns the first idle cycle
    task automatic waitIdle(output int idle_cyc);
        for (int i = 0; i < 400; i++) begin
            tickClock();
            if (!tx_busy) break;
        end
        checkOutput("idle_timeout", {31'd0, tx_busy}, 32'd0);
        idle_cyc = cyc;
    endtask

    initial begin
        int idle_cyc;
        int base_pulses;

        // Reset state
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        applyReset();
        checkOutput("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        checkOutput("rst_transmit", {31'd0, Transmit}, 32'd0);
        checkOutput("rst_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("rst_datatx", {24'd0, DATATX}, 32'd0);
        checkOutput("rst_clear", {31'd0, Clear_RX_Flag}, 32'd0);
        checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rst_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("rst_perr_count", {24'd0, perr_count}, 32'd0);

        // Single frame from requester 0
        applyStimulus(1'b1, 8'h05, 1'b0, 8'h00);
        tx_q.push_back('{who: 1'b0, data: 8'h05});
        tx_pulses = 0;
        tickClock();
        checkOutput("t1_ack_cycle", last_ack_cyc, 32'd1);
        checkOutput("t1_busy_c1", {31'd0, tx_busy}, 32'd1);
        checkOutput("t1_no_tx_c1", {31'd0, Transmit}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        tickClock();
        checkOutput("t1_tx_c2", {31'd0, Transmit}, 32'd1);
        checkOutput("t1_datatx_c2", {24'd0, DATATX}, 32'h05);
        waitIdle(idle_cyc);
        checkOutput("t1_idle_cycle", idle_cyc, 32'd195);
        checkOutput("t1_tx_pulses", tx_pulses, 32'd1);
        checkOutput("t1_tx_cycle", last_tx_cyc, 32'd2);

        // Both requesting continuously from reset: strict alternation
        applyStimulus(1'b1, 8'hA5, 1'b1, 8'h3C);
        reset = 1'b1;
        tickClock();
        tickClock();
        reset = 1'b0;
        cyc = 0;
        tx_q.push_back('{who: 1'b0, data: 8'hA5});
        tx_q.push_back('{who: 1'b1, data: 8'h3C});
        tx_q.push_back('{who: 1'b0, data: 8'hA5});
        ack_cycles.delete();
        base_pulses = tx_pulses;
        for (int i = 0; i < 600; i++) begin
            tickClock();
            if (ack_cycles.size() >= 3) break;
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("t2_ack_count", ack_cycles.size(), 32'd3);
        checkOutput("t2_ack_cyc0", ack_cycles[0], 32'd1);
        checkOutput("t2_ack_cyc1", ack_cycles[1], 32'd196);
        checkOutput("t2_ack_cyc2", ack_cycles[2], 32'd391);
        waitIdle(idle_cyc);
        checkOutput("t2_tx_pulses", tx_pulses - base_pulses, 32'd3);

        // Request from 1 arriving mid-frame waits for the frame to finish
        applyReset();
        applyStimulus(1'b1, 8'h11, 1'b0, 8'h00);
        tx_q.push_back('{who: 1'b0, data: 8'h11});
        tickClock();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        while (cyc < 50) tickClock();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h22);
        tx_q.push_back('{who: 1'b1, data: 8'h22});
        base_pulses = ack_count;
        while (cyc < 100) tickClock();
        checkOutput("t3_datatx_mid", {24'd0, DATATX}, 32'h11);
        checkOutput("t3_no_early_ack", ack_count - base_pulses, 32'd0);
        for (int i = 0; i < 300; i++) begin
            tickClock();
            if (ack_count - base_pulses >= 1) break;
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("t3_ack1_cycle", last_ack_cyc, 32'd196);
        waitIdle(idle_cyc);

        // RX capture with consumer ready; flag left high must not recapture
        base_pulses = clr_count;
        rx_ready    = 1'b1;
        RX_FLAG     = 1'b1;
        DATARX      = 8'h96;
        ParityError = 1'b0;
        rx_q.push_back('{data: 8'h96, perr: 1'b0});
        tickClock();
        checkOutput("t4_rx_valid", {31'd0, rx_valid}, 32'd1);
        tickClock();
        tickClock();
        checkOutput("t4_single_clear", clr_count - base_pulses, 32'd1);
        checkOutput("t4_consumed", {31'd0, rx_valid}, 32'd0);
        RX_FLAG = 1'b0;
        tickClock();

        // Backpressure: second byte waits in the UART until the consumer is ready
        rx_ready    = 1'b0;
        RX_FLAG     = 1'b1;
        DATARX      = 8'h41;
        ParityError = 1'b0;
        rx_q.push_back('{data: 8'h41, perr: 1'b0});
        tickClock();
        RX_FLAG = 1'b0;
        tickClock();
        base_pulses = clr_count;
        RX_FLAG     = 1'b1;
        DATARX      = 8'h7E;
        ParityError = 1'b1;
        rx_q.push_back('{data: 8'h7E, perr: 1'b1});
        tickClock();
        tickClock();
        tickClock();
        checkOutput("t5_no_clear_bp", clr_count - base_pulses, 32'd0);
        checkOutput("t5_held_data", {24'd0, rx_data}, 32'h41);
        checkOutput("t5_held_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("t5_perr_before", {24'd0, perr_count}, 32'd0);
        rx_ready = 1'b1;
        tickClock();
        checkOutput("t5_clear_after", clr_count - base_pulses, 32'd1);
        checkOutput("t5_perr_count", {24'd0, perr_count}, 32'd1);
        checkOutput("t5_valid_replace", {31'd0, rx_valid}, 32'd1);
        RX_FLAG     = 1'b0;
        ParityError = 1'b0;
        tickClock();
        checkOutput("t5_drained", {31'd0, rx_valid}, 32'd0);
        rx_ready = 1'b0;

        // Reset during WAIT with an unconsumed RX byte
        applyReset();
        applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
        tx_q.push_back('{who: 1'b0, data: 8'h5A});
        RX_FLAG     = 1'b1;
        DATARX      = 8'hC3;
        ParityError = 1'b1;
        rx_q.push_back('{data: 8'hC3, perr: 1'b1});
        tickClock();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        RX_FLAG     = 1'b0;
        ParityError = 1'b0;
        while (cyc < 20) tickClock();
        checkOutput("t6_busy_pre", {31'd0, tx_busy}, 32'd1);
        checkOutput("t6_valid_pre", {31'd0, rx_valid}, 32'd1);
        checkOutput("t6_perr_pre", {24'd0, perr_count}, 32'd1);
        reset = 1'b1;
        tickClock();
        checkOutput("t6_busy_rst", {31'd0, tx_busy}, 32'd0);
        checkOutput("t6_valid_rst", {31'd0, rx_valid}, 32'd0);
        checkOutput("t6_perr_rst", {24'd0, perr_count}, 32'd0);
        checkOutput("t6_datatx_rst", {24'd0, DATATX}, 32'd0);
        reset = 1'b0;
        cyc = 0;
        applyStimulus(1'b1, 8'h33, 1'b0, 8'h00);
        tx_q.push_back('{who: 1'b0, data: 8'h33});
        tickClock();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("t6_regrant_cycle", last_ack_cyc, 32'd1);
        waitIdle(idle_cyc);
        checkOutput("t6_idle_cycle", idle_cyc, 32'd195);

        checkOutput("tx_q_drained", tx_q.size(), 32'd0);
        checkOutput("rx_q_drained", rx_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
